// File: rtl/booth_multiplier_seq.sv
// Iterative radix-2 Booth multiplier, one Booth step per clock, signed or unsigned operands.
// Operands are widened by one bit so a single signed datapath handles both modes exactly.
module booth_multiplier_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] FINISH = CW'(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   mcand;
    logic [WIDTH:0]   mplier;
    logic             q_m1;
    logic [CW-1:0]    step;
    logic [WIDTH:0]   ext_m;
    logic [WIDTH:0]   ext_q;
    logic [WIDTH:0]   booth_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (step == FINISH) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Unsigned operands gain a zero MSB, signed ones a copy of their sign bit.
    always_comb begin
        ext_m     = {signed_mode & multiplicand[WIDTH-1], multiplicand};
        ext_q     = {signed_mode & multiplier[WIDTH-1], multiplier};
        booth_sum = acc;
        case ({mplier[0], q_m1})
            2'b10:   booth_sum = acc - mcand;
            2'b01:   booth_sum = acc + mcand;
            default: booth_sum = acc;
        endcase
    end

    // The extra pass with step == FINISH only registers the result, giving a stable product in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            q_m1    <= 1'b0;
            step    <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= ext_m;
                        mplier <= ext_q;
                        acc    <= '0;
                        q_m1   <= 1'b0;
                        step   <= '0;
                    end
                end
                CALC: begin
                    if (step == FINISH) begin
                        product <= {acc[WIDTH-2:0], mplier};
                    end else begin
                        acc    <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        mplier <= {booth_sum[0], mplier[WIDTH:1]};
                        q_m1   <= mplier[0];
                        step   <= step + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Randomized and directed bench for booth_multiplier_seq at WIDTH=8 and WIDTH=16.
// Expected products come from plain integer multiplication of the operands.
module tb_booth_multiplier_seq;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv8, ir8, sm8, ov8, or8;
    logic [7:0]  mc8, mq8;
    logic [15:0] prod8;

    logic        iv16, ir16, sm16, ov16, or16;
    logic [15:0] mc16, mq16;
    logic [31:0] prod16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_multiplier_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .multiplicand(mc8), .multiplier(mq8), .signed_mode(sm8),
        .out_valid(ov8), .out_ready(or8), .product(prod8)
    );

    booth_multiplier_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .multiplicand(mc16), .multiplier(mq16), .signed_mode(sm16),
        .out_valid(ov16), .out_ready(or16), .product(prod16)
    );

    // Reference: interpret operands in the requested mode and multiply as integers.
    function automatic longint unsigned ref_prod(input longint unsigned m, input longint unsigned q,
                                                 input bit s, input int w);
        longint a, b, r;
        longint unsigned mask;
        a = longint'(m);
        b = longint'(q);
        if (s && m[w-1]) a = a - (longint'(1) << w);
        if (s && q[w-1]) b = b - (longint'(1) << w);
        r = a * b;
        mask = (longint'(1) << (2 * w)) - 1;
        return longint'(r) & mask;
    endfunction

    task automatic run8(input logic [7:0] m, input logic [7:0] q, input logic s, input bit toggle,
                        output logic [15:0] p, output int lat);
        @(negedge clk);
        mc8 = m; mq8 = q; sm8 = s; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 100) begin
            if (toggle) begin
                mc8 = 8'($urandom); mq8 = 8'($urandom);
                sm8 = 1'($urandom); iv8 = 1'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        p = prod8;
    endtask

    task automatic release8();
        or8 = 1'b1;
        iv8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv8 = 1'b1; iv16 = 1'b1;
        or8 = 1'b0; or16 = 1'b0;
        mc8 = 8'h12; mq8 = 8'h34; sm8 = 1'b0;
        mc16 = 16'h1234; mq16 = 16'h5678; sm16 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        iv8 = 1'b0; iv16 = 1'b0;
        checks++;
        if (ir8 !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready8: got %b expected 1", ir8); end
        checks++;
        if (ov8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid8: got %b expected 0", ov8); end
        checks++;
        if (prod8 !== 16'h0) begin failures++; $display("[TB] FAIL reset_product8: got %h expected 0000", prod8); end
        checks++;
        if (prod16 !== 32'h0) begin failures++; $display("[TB] FAIL reset_product16: got %h expected 00000000", prod16); end
        @(negedge clk);
        checks++;
        if (ir8 !== 1'b1 || ir16 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_no_accept: got in_ready %b/%b expected 1/1", ir8, ir16);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  tm [6] = '{8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h7F};
        logic [7:0]  tq [6] = '{8'h80, 8'h01, 8'hFF, 8'hA5, 8'hA5, 8'h80};
        logic        ts [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] te [6] = '{16'h4000, 16'hFFFF, 16'hFE01, 16'h0000, 16'h0000, 16'hC080};
        logic [15:0] p;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run8(tm[i], tq[i], ts[i], 1'b0, p, lat);
            checks++;
            if (lat !== 10) begin failures++; $display("[TB] FAIL corner_latency[%0d]: got %0d expected 10", i, lat); end
            checks++;
            if (p !== te[i]) begin failures++; $display("[TB] FAIL corner_product[%0d]: got %h expected %h", i, p, te[i]); end
            release8();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] p;
        int lat;
        int bad = 0;
        run8(8'hC3, 8'h5A, 1'b1, 1'b0, p, lat);
        checks++;
        if (p !== 16'(ref_prod(64'hC3, 64'h5A, 1'b1, 8))) begin
            failures++;
            $display("[TB] FAIL bp_product: got %h expected %h", p, 16'(ref_prod(64'hC3, 64'h5A, 1'b1, 8)));
        end
        for (int i = 0; i < 20; i++) begin
            iv8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (prod8 !== p || ov8 !== 1'b1 || ir8 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
        or8 = 1'b1;
        iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
        iv8 = 1'b0;
        checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", ir8, ov8);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] p;
        int lat;
        int stale = 0;
        @(negedge clk);
        mc8 = 8'h55; mq8 = 8'h33; sm8 = 1'b1; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || prod8 !== 16'h0) begin
            failures++;
            $display("[TB] FAIL midreset_state: got in_ready=%b out_valid=%b product=%h expected 1/0/0000", ir8, ov8, prod8);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ov8 !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("[TB] FAIL midreset_stale: got %0d valid cycles expected 0", stale); end
        run8(8'h07, 8'hFD, 1'b1, 1'b0, p, lat);
        checks++;
        if (p !== 16'hFFEB || lat !== 10) begin
            failures++;
            $display("[TB] FAIL midreset_next: got %h after %0d edges expected FFEB after 10", p, lat);
        end
        release8();
    endtask

    task automatic test_toggle();
        logic [15:0] p;
        logic [7:0] m, q;
        logic s;
        int lat;
        for (int i = 0; i < 8; i++) begin
            m = 8'($urandom); q = 8'($urandom); s = 1'($urandom);
            run8(m, q, s, 1'b1, p, lat);
            checks++;
            if (p !== 16'(ref_prod(64'(m), 64'(q), s, 8)) || lat !== 10) begin
                failures++;
                $display("[TB] FAIL toggle[%0d]: got %h after %0d edges expected %h after 10",
                         i, p, lat, 16'(ref_prod(64'(m), 64'(q), s, 8)));
            end
            release8();
        end
    endtask

    task automatic test_random16();
        logic [31:0] expq[$];
        logic [31:0] e;
        logic [15:0] m, q;
        logic s;
        int cyc;
        bit seen;
        int released = 0;
        for (int n = 0; n < 2000; n++) begin
            m = 16'($urandom); q = 16'($urandom); s = 1'($urandom);
            if (n % 97 == 0) begin m = 16'h8000; q = 16'h8000; end
            @(negedge clk);
            mc16 = m; mq16 = q; sm16 = s; iv16 = 1'b1;
            expq.push_back(32'(ref_prod(64'(m), 64'(q), s, 16)));
            @(posedge clk);
            @(negedge clk);
            iv16 = 1'b0;
            mc16 = 16'($urandom); mq16 = 16'($urandom); sm16 = 1'($urandom);
            cyc = 0;
            seen = 1'b0;
            while (cyc < 200) begin
                or16 = 1'($urandom);
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (seen && ir16) begin
                    released++;
                    break;
                end
                if (ov16 && !seen) begin
                    seen = 1'b1;
                    e = expq.pop_front();
                    checks++;
                    if (prod16 !== e || cyc !== 18) begin
                        failures++;
                        $display("[TB] FAIL rand16[%0d]: got %h at cycle %0d expected %h at cycle 18", n, prod16, cyc, e);
                    end
                end
            end
            or16 = 1'b0;
            if (cyc >= 200) begin
                checks++;
                failures++;
                $display("[TB] FAIL rand16_timeout[%0d]: got no release expected release within 200 cycles", n);
                break;
            end
        end
        checks++;
        if (released != 2000 || expq.size() != 0) begin
            failures++;
            $display("[TB] FAIL rand16_count: got %0d products expected 2000", released);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_corners();
        test_backpressure();
        test_reset_mid_calc();
        test_toggle();
        test_random16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
